// File: rtl/window_5x5_gen.sv
// window_5x5_gen
// Streaming 5x5 neighbourhood generator for the 25-input sorter.
// A raster-order pixel stream is accepted one pixel per in_valid cycle. Four
// line buffers hold the previous four lines. A registered 25-element window
// is presented, with a one-cycle strobe, whenever a full interior 5x5
// neighbourhood is available. Border windows are not produced.
//
// Handshake: in_valid qualifies in_data/in_sof on a rising clock edge. There
// is no ready signal; every valid pixel is accepted. In cycles with
// in_valid=0 all state holds, so gaps do not change the window contents.
//
// Ports:
//   clock       rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    pixel transfer qualifier
//   in_sof      start of frame; forces the pixel to (row 0, col 0)
//   in_data     pixel value
//   win_valid   registered strobe: win_data holds a new complete window
//   win_data    element k=r*5+c at [k*DSIZE +: DSIZE]; r=0 oldest line,
//               c=0 oldest column, k=12 is the centre
//   frame_done  one-cycle pulse after the last pixel of a frame
module window_5x5_gen #(
  parameter int DSIZE = 64,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int LB_AW = 10
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [DSIZE-1:0]     in_data,
  output logic                 win_valid,
  output logic [25*DSIZE-1:0]  win_data,
  output logic                 frame_done
);

  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [LB_AW-1:0] COL_LAST = LB_AW'(IMG_W - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
  localparam logic [LB_AW-1:0] COL_MIN  = LB_AW'(4);
  localparam logic [RW-1:0]    ROW_MIN  = RW'(4);

  logic [LB_AW-1:0] col;
  logic [RW-1:0]    row;
  logic [LB_AW-1:0] col_eff;
  logic [RW-1:0]    row_eff;
  logic             sof_take;

  // Line RAM is intentionally not reset; rows 0..3 of every frame are gated
  // out of win_valid, so stale contents never reach a valid window.
  logic [DSIZE-1:0] lb    [4][IMG_W];
  logic [DSIZE-1:0] lb_rd [4];
  logic [DSIZE-1:0] new_col [5];
  logic [DSIZE-1:0] win   [25];

  // A start-of-frame pixel is taken as (0,0) whatever the counters say.
  always_comb begin
    sof_take = in_valid && in_sof;
    col_eff  = sof_take ? '0 : col;
    row_eff  = sof_take ? '0 : row;
  end

  // Read-old-data: the value read at col_eff this cycle is the one written
  // one line earlier; the write below lands at the clock edge.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      lb_rd[n] = lb[n][col_eff];
    end
  end

  always_ff @(posedge clock) begin
    if (in_valid) begin
      lb[0][col_eff] <= in_data;
      for (int n = 1; n < 4; n++) begin
        lb[n][col_eff] <= lb_rd[n-1];
      end
    end
  end

  // Incoming column, oldest line at r=0.
  always_comb begin
    new_col[0] = lb_rd[3];
    new_col[1] = lb_rd[2];
    new_col[2] = lb_rd[1];
    new_col[3] = lb_rd[0];
    new_col[4] = in_data;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < 25; k++) begin
        win[k] <= '0;
      end
    end else begin
      win_valid  <= in_valid && (row_eff >= ROW_MIN) && (col_eff >= COL_MIN);
      frame_done <= in_valid && (row_eff == ROW_LAST) && (col_eff == COL_LAST);
      if (in_valid) begin
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) begin
            win[r*5+c] <= win[r*5+c+1];
          end
          win[r*5+4] <= new_col[r];
        end
        if (col_eff == COL_LAST) begin
          col <= '0;
          row <= (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
        end else begin
          col <= col_eff + LB_AW'(1);
          row <= row_eff;
        end
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < 25; k++) begin
      win_data[k*DSIZE +: DSIZE] = win[k];
    end
  end

endmodule

// File: tb/tb_window_5x5_gen.sv
module tb_window_5x5_gen;
  localparam int DSIZE = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int LB_AW = 3;
  localparam int WW    = 25 * DSIZE;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [7:0]    in_data = '0;
  logic          win_valid;
  logic [WW-1:0] win_data;
  logic          frame_done;

  always #5 clock = ~clock;

  window_5x5_gen #(
    .DSIZE(DSIZE), .IMG_W(IMG_W), .IMG_H(IMG_H), .LB_AW(LB_AW)
  ) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .win_valid(win_valid), .win_data(win_data),
    .frame_done(frame_done)
  );

  int tests = 0;
  int fails = 0;
  int fd_seen = 0;

  // Image coordinates of the pixel currently on the inputs, as the stimulus
  // intends them (the model never looks at the DUT's counters).
  int cur_r = 0;
  int cur_c = 0;

  logic [7:0]    img [IMG_H][IMG_W];
  logic [WW-1:0] exp_q [$];
  logic [WW-1:0] got_q [$];
  logic [WW-1:0] mw;
  logic          exp_valid = 1'b0;
  logic          exp_fd = 1'b0;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] k_of(input logic [WW-1:0] w, input int k);
    return w[k*8 +: 8];
  endfunction

  // ---------------- model ----------------
  // A window exists for every accepted pixel at (r>=4, c>=4); it is the
  // 5x5 block of the image ending at that pixel.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid = 1'b0;
      exp_fd    = 1'b0;
      exp_q.delete();
    end else begin
      exp_valid = 1'b0;
      exp_fd    = 1'b0;
      if (in_valid) begin
        img[cur_r][cur_c] = in_data;
        if (cur_r >= 4 && cur_c >= 4) begin
          mw = '0;
          for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
              mw[(r*5+c)*8 +: 8] = img[cur_r-4+r][cur_c-4+c];
          exp_q.push_back(mw);
          exp_valid = 1'b1;
        end
        if (cur_r == IMG_H-1 && cur_c == IMG_W-1) exp_fd = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clock) begin
    if (rst_n) begin
      check("win_valid", win_valid, exp_valid);
      check("frame_done", frame_done, exp_fd);
      if (frame_done) begin
        fd_seen++;
        check("fd_with_valid", win_valid, 1);
      end
      if (win_valid) got_q.push_back(win_data);
      if (exp_valid && exp_q.size() > 0) begin
        mw = exp_q.pop_front();
        if (win_valid) check("win_data", win_data, mw);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_px(input int r, input int c, input logic [7:0] v,
                          input logic sof, input int gap_pct);
    while ($urandom_range(0, 99) < gap_pct) begin
      @(negedge clock);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
    end
    @(negedge clock);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = v;
    cur_r    = r;
    cur_c    = c;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  task automatic send_rows(input int base, input int rows, input int last_cols,
                           input logic first_sof, input int gap_pct);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < IMG_W; c++)
        if (r < rows-1 || c < last_cols)
          drive_px(r, c, 8'(base + r*16 + c), first_sof && r == 0 && c == 0, gap_pct);
  endtask

  task automatic check_win(input string tag, input int idx,
                           input logic [7:0] e0, input logic [7:0] e12, input logic [7:0] e24);
    if (idx >= got_q.size()) begin
      check({tag, "_missing"}, got_q.size(), idx + 1);
    end else begin
      check({tag, "_k0"},  k_of(got_q[idx], 0),  e0);
      check({tag, "_k12"}, k_of(got_q[idx], 12), e12);
      check({tag, "_k24"}, k_of(got_q[idx], 24), e24);
    end
  endtask

  task automatic start_scn();
    got_q.delete();
    fd_seen = 0;
  endtask

  task automatic check_plain_frame(input string tag, input int base_idx);
    check_win({tag, "_first"}, base_idx + 0, 8'h00, 8'h22, 8'h44);
    check_win({tag, "_wrap"},  base_idx + 4, 8'h10, 8'h32, 8'h54);
    check_win({tag, "_last"},  base_idx + 7, 8'h13, 8'h35, 8'h57);
  endtask

  task automatic finish_bench();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  initial begin
    #100000;
    fails++;
    $display("FAIL timeout: simulation did not complete within time bound");
    finish_bench();
  end

  // ---------------- stimulus ----------------
  initial begin
    logic bad;
    repeat (3) @(negedge clock);
    check("rst_win_valid", win_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_win_data", win_data, 0);
    rst_n = 1'b1;
    idle(2);

    // 1: gap-free frame (also covers the column-wrap window at (5,4))
    start_scn();
    send_rows(0, IMG_H, IMG_W, 1'b0, 0);
    idle(3);
    check("s1_count", got_q.size(), 8);
    check("s1_fd_count", fd_seen, 1);
    check_plain_frame("s1", 0);

    // 2: same frame with ~40% idle cycles
    start_scn();
    send_rows(0, IMG_H, IMG_W, 1'b0, 40);
    idle(3);
    check("s2_count", got_q.size(), 8);
    check("s2_fd_count", fd_seen, 1);
    check_plain_frame("s2", 0);

    // 3: two back-to-back frames, second offset by 0x80
    start_scn();
    send_rows(0, IMG_H, IMG_W, 1'b0, 0);
    send_rows(8'h80, IMG_H, IMG_W, 1'b0, 0);
    idle(3);
    check("s3_count", got_q.size(), 16);
    check("s3_fd_count", fd_seen, 2);
    check_win("s3_f2_first", 8, 8'h80, 8'hA2, 8'hC4);
    for (int i = 8; i < 16 && i < got_q.size(); i++) begin
      bad = 1'b0;
      for (int k = 0; k < 25; k++)
        if (k_of(got_q[i], k) < 8'h80 || k_of(got_q[i], k) > 8'hD7) bad = 1'b1;
      check("s3_f2_range", bad, 0);
    end

    // 4: truncated frame (rows 0..3, sof at row 3 col 5), then full frame
    start_scn();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < IMG_W; c++)
        if (r < 3 || c < 5) drive_px(r, c, 8'hEE, 1'b0, 0);
    send_rows(0, IMG_H, IMG_W, 1'b1, 0);
    idle(3);
    check("s4_count", got_q.size(), 8);
    check("s4_fd_count", fd_seen, 1);
    check_plain_frame("s4", 0);
    for (int i = 0; i < got_q.size(); i++) begin
      bad = 1'b0;
      for (int k = 0; k < 25; k++)
        if (k_of(got_q[i], k) == 8'hEE) bad = 1'b1;
      check("s4_no_presof", bad, 0);
    end

    // 5: reset pulsed at row 5 col 2, then a full frame
    start_scn();
    send_rows(0, 6, 2, 1'b0, 0);
    idle(1);
    check("s5_pre_rst_nonzero", (win_data != '0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_rst_win_valid", win_valid, 0);
    check("s5_rst_frame_done", frame_done, 0);
    check("s5_rst_win_data", win_data, 0);
    idle(3);
    rst_n = 1'b1;
    start_scn();
    send_rows(0, IMG_H, IMG_W, 1'b0, 0);
    idle(3);
    check("s5_count", got_q.size(), 8);
    check("s5_fd_count", fd_seen, 1);
    check_plain_frame("s5", 0);

    check("exp_q_drained", exp_q.size(), 0);
    finish_bench();
  end

endmodule

// File: doc/window_5x5_gen.md
Name: window_5x5_gen

Overview:
- Streaming 5x5 neighbourhood generator that feeds the 25-input order/sort pipeline (inputs 00..24).
- Takes a raster-order pixel stream, one pixel per accepted cycle, and buffers four previous lines in on-chip line RAM.
- Presents a registered 25-element window with a valid strobe each time a full interior 5x5 window is available.
- Sits between the pixel source and the sorter; the sorter's fixed pipeline latency is tracked downstream.

Parameters:
DSIZE, 64, pixel/element width in bits (matches sorter element width)
IMG_W, 640, pixels per line; legal range 5..2^LB_AW
IMG_H, 480, lines per frame; minimum 5
LB_AW, 10, line-buffer address width; requires 2^LB_AW >= IMG_W

Ports:
clock  in  1  single clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  pixel transfer qualifier; no back-pressure, source is never stalled
in_sof  in  1  start of frame; meaningful only when in_valid=1
in_data  in  DSIZE  pixel value
win_valid  out  1  registered strobe: win_data holds a new complete window
win_data  out  25*DSIZE  window, element k=r*5+c at [k*DSIZE +: DSIZE]; r=0 oldest line, c=0 oldest column; k=12 is the centre; k maps to sorter input idk
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (async assert, deasserted synchronously by the environment): win_valid=0, frame_done=0, win_data=0, col=0, row=0. Line-RAM contents are not cleared; row gating masks stale data.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance only on in_valid=1. When col=IMG_W-1, col wraps to 0 and row increments. When row=IMG_H-1 and col=IMG_W-1, both wrap to 0, so the next frame starts implicitly.
- in_sof=1 with in_valid=1: that pixel is taken as row 0, col 0 regardless of counter state, and counting continues from there. This resynchronises a truncated frame. in_sof with in_valid=0 is ignored.
- Line buffers LB0..LB3, each IMG_W deep, addressed by col:
  - on in_valid, each buffer is read at col and then written at col (read-old-data semantics);
  - LB0 is written with in_data, LBn with LBn-1's read data;
  - LB3 read data is the line 4 rows above.
- Window shift on in_valid:
  - all 5 rows shift one column toward c=0;
  - new column c=4 is {r0: LB3 out, r1: LB2 out, r2: LB1 out, r3: LB0 out, r4: in_data}.
- Window storage and win_data are registered; in_valid=0 holds all state (stall transparent).
- win_valid is 1 in the cycle after an accepted pixel with row>=4 and col>=4, else 0. Latency is 1 clock from the accepted pixel to its window.
- No border padding: each frame produces (IMG_W-4)*(IMG_H-4) windows. Windows never straddle a line wrap because of the col>=4 gate.
- frame_done asserts in the cycle after the pixel at (IMG_H-1, IMG_W-1) is accepted, coincident with the last win_valid.
- Reset mid-frame: all outputs go to their reset values immediately. After release the next accepted pixel is (0,0); no window is emitted until 4 full lines are refilled.
- Gap cycles (in_valid=0) between and within lines are arbitrary; output content equals the gap-free case.

Test Plan (IMG_W=8, IMG_H=6, DSIZE=8, pixel = row*16+col unless noted):
1. Single gap-free frame -> first win_valid one cycle after pixel 36 (row 4, col 4) with k0=0x00, k12=0x22, k24=0x44; exactly 8 win_valid pulses; last window k24=0x57; frame_done coincident with the last pulse.
2. Random in_valid gaps (~40% idle) over the same frame -> identical sequence of 8 windows; win_data and win_valid stable or 0 during gaps; no extra pulses.
3. Two back-to-back frames without in_sof, second frame pixel = 0x80+row*16+col -> second frame windows contain only 0x8x..0xDx values; first window of frame 2 has k0=0x80, k24=0xC4.
4. in_sof asserted at row 3 col 5 of frame 1, then a full frame -> counters restart; exactly 8 windows, all built from post-sof pixels; first window k0=0x00, k24=0x44.
5. rst_n pulsed low at row 5 col 2 -> win_valid, frame_done and win_data go to 0 asynchronously; a following full frame behaves exactly as in scenario 1.
6. Column-wrap check: the pulse at (row 5, col 4) follows (row 4, col 7) with no window emitted at row 5 cols 0..3; its k0 = 0x10 and k24 = 0x54.
